// File: rtl/sel_enc_seq.sv
// sel_enc_seq
// Sequences one register-transfer instruction through bus read, execute-wait
// and write-back phases, producing one-hot register select buses.
//
// Ports:
//   clock       - single clock, all state changes on its rising edge
//   clear       - synchronous active-high reset
//   start       - request to sequence one instruction (sampled in IDLE only)
//   ir_in       - instruction word, Ra=[26:23], Rb=[22:19], Rc=[18:15]
//   base_mode   - Rb read uses base-address gating (drives BAOut)
//   use_rc      - instruction also reads Rc
//   wb_en       - instruction writes Ra
//   ex_cycles   - execute wait cycles minus one (0-7)
//   reg_out     - one-hot register-to-bus select
//   reg_enable  - one-hot register write enable
//   BAOut       - forces the selected register's bus output to zero
//   busy        - high whenever the sequencer is not idle
//   done        - single-cycle completion pulse
module sel_enc_seq #(
  parameter int NUM_REGS = 16,
  parameter int IR_WIDTH = 32
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic                base_mode,
  input  logic                use_rc,
  input  logic                wb_en,
  input  logic [2:0]          ex_cycles,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                BAOut,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    READ_B,
    READ_C,
    EXEC,
    WRITE_A,
    DONE
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [2:0] cnt;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       ba;
  logic       rcUsed;
  logic       wb;
  logic [2:0] ex;

  // Only the three register fields of the instruction word matter here.
  logic unused_ir;
  assign unused_ir = ^{ir_in[IR_WIDTH-1:27], ir_in[14:0]};

  // Index to one-hot select; indices past the register file give no select.
  function automatic logic [NUM_REGS-1:0] decode(input logic [3:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // State, execute counter and instruction fields. Fields are captured only
  // when a start is accepted, so inputs may change freely while busy. The
  // counter is loaded on entry to EXEC and counts down to zero inside it.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      ra     <= 4'd0;
      rb     <= 4'd0;
      rc     <= 4'd0;
      ba     <= 1'b0;
      rcUsed <= 1'b0;
      wb     <= 1'b0;
      ex     <= 3'd0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        ra     <= ir_in[26:23];
        rb     <= ir_in[22:19];
        rc     <= ir_in[18:15];
        ba     <= base_mode;
        rcUsed <= use_rc;
        wb     <= wb_en;
        ex     <= ex_cycles;
      end
      if (nxt == EXEC && state != EXEC) begin
        cnt <= ex;
      end else if (state == EXEC && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  // Next-state logic. EXEC is left once the counter has reached zero, which
  // gives ex_cycles+1 cycles in EXEC.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = READ_B;
      READ_B:  nxt = rcUsed ? READ_C : EXEC;
      READ_C:  nxt = EXEC;
      EXEC:    if (cnt == 3'd0) nxt = wb ? WRITE_A : DONE;
      WRITE_A: nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs depend only on the registered state and captured fields, so the
  // select buses are glitch-free relative to the inputs.
  always_comb begin
    reg_out    = '0;
    reg_enable = '0;
    BAOut      = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      READ_B: begin
        reg_out = decode(rb);
        BAOut   = ba;
      end
      READ_C:  reg_out    = decode(rc);
      WRITE_A: reg_enable = decode(ra);
      DONE:    done       = 1'b1;
      default: ;
    endcase
  end

endmodule
